// File: rtl/cdc_pkg.sv
// Shared definitions for the fast-to-slow CDC transmit blocks.
package cdc_pkg;

  localparam int unsigned CDC_DATA_W      = 8;
  localparam int unsigned CDC_HOLD_CYCLES = 12;

  // Channel transmit FSM: waiting for a request, or holding a captured word.
  typedef enum logic {
    CDC_IDLE = 1'b0,
    CDC_HOLD = 1'b1
  } cdc_tx_state_e;

  // Width of a binary index into n requesters (at least one bit).
  function automatic int unsigned cdc_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdc_fs_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from
// the slot after the last winner, wrapping at NUM_REQ.
module rr_pick
  import cdc_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = cdc_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] winner_oh_c,
  output logic [IDX_W-1:0]   winner_idx_c,
  output logic               valid_c
);

  // Priority scan starting at last+1; the first hit wins.
  always_comb begin
    int unsigned idx;
    winner_oh_c  = '0;
    winner_idx_c = '0;
    valid_c      = 1'b0;
    idx          = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last) + k) % NUM_REQ;
      if (!valid_c && req[IDX_W'(idx)]) begin
        valid_c      = 1'b1;
        winner_idx_c = IDX_W'(idx);
        winner_oh_c  = NUM_REQ'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/cdc_fs_tx_arbiter.sv
// Round-robin arbiter sharing one fast-to-slow word synchronizer channel.
// A captured word is held for HOLD_CYCLES fast clocks so the slow side
// samples a settled value; xfer_toggle flips once per capture.
module cdc_fs_tx_arbiter
  import cdc_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = CDC_DATA_W,
  parameter int unsigned HOLD_CYCLES = CDC_HOLD_CYCLES
) (
  input  logic                      fast_clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic [NUM_REQ-1:0]        grant,
  output logic [DATA_W-1:0]         data_out,
  output logic                      xfer_toggle,
  output logic                      busy
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES);
  localparam int unsigned IDX_W = cdc_idx_w(NUM_REQ);

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  cdc_tx_state_e      state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   last, last_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [DATA_W-1:0]  data_nxt;
  logic               toggle_nxt;
  logic               busy_nxt;

  logic [NUM_REQ-1:0] pick_oh_c;
  logic [IDX_W-1:0]   pick_idx_c;
  logic               pick_valid_c;

  logic [DATA_W-1:0]  words [NUM_REQ];

  // Split the flat requester bus into per-requester words.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
    assign words[g] = data_in[g*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req          (req),
    .last         (last),
    .winner_oh_c  (pick_oh_c),
    .winner_idx_c (pick_idx_c),
    .valid_c      (pick_valid_c)
  );

  // Next-state and output decode: capture in IDLE, count down in HOLD.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    last_nxt   = last;
    grant_nxt  = '0;
    data_nxt   = data_out;
    toggle_nxt = xfer_toggle;
    busy_nxt   = busy;
    unique case (state)
      CDC_IDLE: begin
        if (pick_valid_c) begin
          grant_nxt  = pick_oh_c;
          data_nxt   = words[pick_idx_c];
          toggle_nxt = ~xfer_toggle;
          busy_nxt   = 1'b1;
          cnt_nxt    = CNT_LOAD;
          last_nxt   = pick_idx_c;
          state_nxt  = CDC_HOLD;
        end
      end
      CDC_HOLD: begin
        if (cnt == '0) begin
          busy_nxt  = 1'b0;
          state_nxt = CDC_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = CDC_IDLE;
      end
    endcase
  end

  // State, pointer and registered channel outputs.
  always_ff @(posedge fast_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= CDC_IDLE;
      cnt         <= '0;
      last        <= LAST_RST;
      grant       <= '0;
      data_out    <= '0;
      xfer_toggle <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      last        <= last_nxt;
      grant       <= grant_nxt;
      data_out    <= data_nxt;
      xfer_toggle <= toggle_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule
